// File: rtl/irq_ctrl_if.sv
// Signal bundle between the interrupt controller (slave) and the CPU/peripheral side (master).
// irq_take is a single-cycle strobe and has no back-pressure: the take only happens
// when cpu_ready was high at the granting edge, so the CPU must honour irq_take
// in the cycle it is seen. reti is sampled only while the handler is in service.
interface irq_ctrl_if #(
  parameter int N_IRQ = 2,
  parameter int AW    = 10
);
  logic [N_IRQ-1:0] irq;
  logic             ei;
  logic             di;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_d;
  logic             cpu_ready;
  logic             reti;
  logic             irq_take;
  logic [AW-1:0]    irq_vec;
  logic [2:0]       irq_id;
  logic             in_service;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             gie;
  logic [1:0]       state_dbg;

  modport master (
    output irq, ei, di, mask_we, mask_d, cpu_ready, reti,
    input  irq_take, irq_vec, irq_id, in_service, pending, mask, gie, state_dbg
  );

  modport slave (
    input  irq, ei, di, mask_we, mask_d, cpu_ready, reti,
    output irq_take, irq_vec, irq_id, in_service, pending, mask, gie, state_dbg
  );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-triggered, fixed-priority, non-nesting interrupt controller with per-source
// mask, global enable and vector generation; state is visible on state_dbg.
module irq_ctrl #(
  parameter int              N_IRQ      = 2,
  parameter int              AW         = 10,
  parameter logic [AW-1:0]   VEC_BASE   = 10'h3F0,
  parameter int              VEC_STRIDE = 2
) (
  input  logic        clk,
  input  logic        reset,
  irq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAKE    = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] msk_q, msk_d;
  logic             gie_q, gie_d;
  logic [2:0]       id_q, id_d;
  logic [AW-1:0]    vec_q, vec_d;

  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] clr;
  logic [2:0]       sel_id;
  logic [AW-1:0]    vec_off;
  logic             grant;

  assign edge_det = bus.irq & ~irq_q;
  assign req      = pend_q & msk_q;

  // Lowest index wins: scan downward so the last hit is the smallest set bit.
  always_comb begin
    sel_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel_id = 3'(i);
    end
  end

  assign vec_off = AW'(32'(sel_id) * 32'(VEC_STRIDE));

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((|req) && gie_q && bus.cpu_ready) begin
          grant   = 1'b1;
          state_d = S_TAKE;
        end
      end
      S_TAKE:    state_d = S_SERVICE;
      S_SERVICE: if (bus.reti) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clr   = '0;
    id_d  = id_q;
    vec_d = vec_q;
    if (grant) begin
      for (int i = 0; i < N_IRQ; i++) begin
        clr[i] = (sel_id == 3'(i));
      end
      id_d  = sel_id;
      vec_d = VEC_BASE + vec_off;
    end
    // A fresh edge on the source being cleared must survive, so set is applied last.
    pend_d = (pend_q & ~clr) | edge_det;
    msk_d  = bus.mask_we ? bus.mask_d : msk_q;
    if (bus.di)      gie_d = 1'b0;
    else if (bus.ei) gie_d = 1'b1;
    else             gie_d = gie_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      msk_q   <= '0;
      gie_q   <= 1'b0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      state_q <= state_d;
      irq_q   <= bus.irq;
      pend_q  <= pend_d;
      msk_q   <= msk_d;
      gie_q   <= gie_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end

  assign bus.irq_take   = (state_q == S_TAKE);
  assign bus.in_service = (state_q != S_IDLE);
  assign bus.irq_id     = id_q;
  assign bus.irq_vec    = vec_q;
  assign bus.pending    = pend_q;
  assign bus.mask       = msk_q;
  assign bus.gie        = gie_q;
  assign bus.state_dbg  = state_q;

endmodule
